// File: rtl/fwd_sel_ctrl.sv
// Registered forwarding-select generator for the two EX operand muxes,
// with load-use hazard detection and bubble injection.
module fwd_sel_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic             id_rn_used,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_rm_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_flush,
  output logic [1:0]       ex_sel_a,
  output logic [1:0]       ex_sel_b,
  output logic             ex_valid,
  output logic             id_stall
);

  localparam logic [REG_W-1:0] XZR = REG_W'(ZERO_REG);

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_EXM  = 2'b01;
  localparam logic [1:0] SEL_MWB  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  logic [REG_W-1:0] ex_rd;
  logic             ex_wr;
  logic             ex_ld;
  logic             mem_valid;
  logic [REG_W-1:0] mem_rd;
  logic             mem_wr;

  logic [1:0] sel_a_next;
  logic [1:0] sel_b_next;
  logic       hit_a;
  logic       hit_b;
  logic       bubble;

  // Younger producer (EX) is checked before the older one (MEM).
  function automatic logic [1:0] sel_code(
    input logic             used,
    input logic [REG_W-1:0] src,
    input logic             exv,
    input logic             exw,
    input logic [REG_W-1:0] exr,
    input logic             memv,
    input logic             memw,
    input logic [REG_W-1:0] memr
  );
    logic [1:0] code;
    code = SEL_RF;
    if (!used)
      code = SEL_RF;
    else if (src == XZR)
      code = SEL_ZERO;
    else if (exv && exw && (exr == src))
      code = SEL_EXM;
    else if (memv && memw && (memr == src))
      code = SEL_MWB;
    return code;
  endfunction

  always_comb begin
    sel_a_next = sel_code(id_rn_used, id_rn, ex_valid, ex_wr, ex_rd,
                          mem_valid, mem_wr, mem_rd);
    sel_b_next = sel_code(id_rm_used, id_rm, ex_valid, ex_wr, ex_rd,
                          mem_valid, mem_wr, mem_rd);
    hit_a      = id_rn_used && (id_rn == ex_rd);
    hit_b      = id_rm_used && (id_rm == ex_rd);
    id_stall   = id_valid && ex_valid && ex_ld && ex_wr && (ex_rd != XZR)
                 && (hit_a || hit_b);
    bubble     = ex_flush || id_stall || !id_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_wr     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_sel_a  <= SEL_RF;
      ex_sel_b  <= SEL_RF;
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      mem_wr    <= 1'b0;
    end else begin
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_wr    <= ex_wr;
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_wr    <= 1'b0;
        ex_ld    <= 1'b0;
        ex_sel_a <= SEL_RF;
        ex_sel_b <= SEL_RF;
      end else begin
        ex_valid <= 1'b1;
        ex_rd    <= id_rd;
        ex_wr    <= id_reg_write;
        ex_ld    <= id_mem_read;
        ex_sel_a <= sel_a_next;
        ex_sel_b <= sel_b_next;
      end
    end
  end

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Self-checking bench for fwd_sel_ctrl: directed vector table, mid-stream
// reset sequence, and randomized traffic against an age-ordered history model.
module tb_fwd_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rn;
  logic       id_rn_used;
  logic [4:0] id_rm;
  logic       id_rm_used;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       ex_flush;
  logic [1:0] ex_sel_a;
  logic [1:0] ex_sel_b;
  logic       ex_valid;
  logic       id_stall;

  int passed = 0;
  int total  = 0;

  fwd_sel_ctrl #(.REG_W(5), .ZERO_REG(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rn(id_rn), .id_rn_used(id_rn_used),
    .id_rm(id_rm), .id_rm_used(id_rm_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_flush(ex_flush), .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b),
    .ex_valid(ex_valid), .id_stall(id_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rn;
    logic       rn_used;
    logic [4:0] rm;
    logic       rm_used;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       flush;
    logic       e_stall;
    logic [1:0] e_a;
    logic [1:0] e_b;
    logic       e_valid;
  } vec_t;

  // Reference history: entry 0 is the instruction now in EX, entry 1 in MEM.
  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } slot_t;

  slot_t      hist[2];
  logic [1:0] m_a;
  logic [1:0] m_b;
  logic       m_valid;

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] ref_sel(input logic u, input logic [4:0] s);
    if (!u) return 2'd0;
    if (s == 5'd31) return 2'd3;
    for (int age = 0; age < 2; age++)
      if (hist[age].valid && hist[age].wr && hist[age].rd == s) return 2'(age + 1);
    return 2'd0;
  endfunction

  function automatic logic ref_stall();
    if (!id_valid || !hist[0].valid || !hist[0].ld || !hist[0].wr) return 1'b0;
    if (hist[0].rd == 5'd31) return 1'b0;
    return (id_rn_used && id_rn == hist[0].rd) || (id_rm_used && id_rm == hist[0].rd);
  endfunction

  task automatic model_reset();
    hist[0] = '{default: 0};
    hist[1] = '{default: 0};
    m_a = 0; m_b = 0; m_valid = 0;
  endtask

  task automatic model_clock();
    logic [1:0] a, b;
    logic       st;
    a  = ref_sel(id_rn_used, id_rn);
    b  = ref_sel(id_rm_used, id_rm);
    st = ref_stall();
    hist[1] = hist[0];
    if (ex_flush || st || !id_valid) begin
      hist[0] = '{default: 0};
      m_a = 0; m_b = 0; m_valid = 0;
    end else begin
      hist[0] = '{valid: 1, rd: id_rd, wr: id_reg_write, ld: id_mem_read};
      m_a = a; m_b = b; m_valid = 1;
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    id_valid     = v.valid;
    id_rn        = v.rn;
    id_rn_used   = v.rn_used;
    id_rm        = v.rm;
    id_rm_used   = v.rm_used;
    id_rd        = v.rd;
    id_reg_write = v.wr;
    id_mem_read  = v.ld;
    ex_flush     = v.flush;
  endtask

  task automatic check_output(input string tag, input logic [1:0] a,
                              input logic [1:0] b, input logic v);
    check_val({tag, "_sel_a"}, ex_sel_a, a);
    check_val({tag, "_sel_b"}, ex_sel_b, b);
    check_val({tag, "_valid"}, ex_valid, v);
  endtask

  vec_t vecs[17];
  vec_t rv;

  initial begin
    //             vld rn    ru rm    mu rd     wr ld fl  st a  b  v
    vecs[0]  = '{1, 5'd2,  1, 5'd3,  1, 5'd1,  1, 0, 0, 0, 0, 0, 1};
    vecs[1]  = '{1, 5'd1,  1, 5'd2,  1, 5'd6,  1, 0, 0, 0, 1, 0, 1};
    vecs[2]  = '{1, 5'd0,  0, 5'd0,  0, 5'd3,  1, 0, 0, 0, 0, 0, 1};
    vecs[3]  = '{1, 5'd7,  1, 5'd8,  1, 5'd9,  1, 0, 0, 0, 0, 0, 1};
    vecs[4]  = '{1, 5'd6,  0, 5'd3,  1, 5'd10, 1, 0, 0, 0, 0, 2, 1};
    vecs[5]  = '{1, 5'd0,  0, 5'd0,  0, 5'd4,  1, 0, 0, 0, 0, 0, 1};
    vecs[6]  = '{1, 5'd0,  0, 5'd0,  0, 5'd4,  1, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{1, 5'd4,  1, 5'd0,  0, 5'd11, 0, 0, 0, 0, 1, 0, 1};
    vecs[8]  = '{1, 5'd1,  1, 5'd0,  0, 5'd5,  1, 1, 0, 0, 0, 0, 1};
    vecs[9]  = '{1, 5'd5,  1, 5'd0,  0, 5'd12, 1, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{1, 5'd5,  1, 5'd0,  0, 5'd12, 1, 0, 0, 0, 2, 0, 1};
    vecs[11] = '{1, 5'd0,  0, 5'd0,  0, 5'd31, 1, 1, 0, 0, 0, 0, 1};
    vecs[12] = '{1, 5'd31, 1, 5'd31, 1, 5'd13, 1, 0, 0, 0, 3, 3, 1};
    vecs[13] = '{1, 5'd0,  0, 5'd0,  0, 5'd5,  1, 1, 0, 0, 0, 0, 1};
    vecs[14] = '{1, 5'd5,  1, 5'd0,  0, 5'd12, 1, 0, 1, 1, 0, 0, 0};
    vecs[15] = '{1, 5'd5,  1, 5'd0,  0, 5'd12, 1, 0, 0, 0, 2, 0, 1};
    vecs[16] = '{0, 5'd12, 1, 5'd5,  1, 5'd0,  0, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    id_valid = 0; id_rn = 0; id_rn_used = 0; id_rm = 0; id_rm_used = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; ex_flush = 0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset", 2'd0, 2'd0, 1'b0);
    check_val("reset_stall", id_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_val($sformatf("vec%0d_stall", i), id_stall, vecs[i].e_stall);
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d", i), vecs[i].e_a, vecs[i].e_b, vecs[i].e_valid);
    end

    // Load followed by dependent reader, then reset in the middle of the stall.
    rv = '{1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 0, 1};
    apply_stimulus(rv);
    @(posedge clk);
    #1;
    check_output("rst_load", 2'd0, 2'd0, 1'b1);
    rv = '{1, 5'd5, 1, 5'd5, 1, 5'd7, 1, 0, 0, 1, 0, 0, 0};
    apply_stimulus(rv);
    #1;
    check_val("rst_pre_stall", id_stall, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_async", 2'd0, 2'd0, 1'b0);
    check_val("rst_async_stall", id_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_post_stall", id_stall, 0);
    @(posedge clk);
    #1;
    check_output("rst_post", 2'd0, 2'd0, 1'b1);

    // Randomized traffic over a small register pool so hazards occur often.
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      id_valid     = ($urandom_range(7) != 0);
      id_rn        = ($urandom_range(9) == 0) ? 5'd31 : 5'($urandom_range(5));
      id_rn_used   = ($urandom_range(4) != 0);
      id_rm        = ($urandom_range(9) == 0) ? 5'd31 : 5'($urandom_range(5));
      id_rm_used   = ($urandom_range(4) != 0);
      id_rd        = ($urandom_range(9) == 0) ? 5'd31 : 5'($urandom_range(5));
      id_reg_write = ($urandom_range(4) != 0);
      id_mem_read  = ($urandom_range(2) == 0);
      ex_flush     = ($urandom_range(9) == 0);
      #1;
      check_val($sformatf("rnd%0d_stall", c), id_stall, ref_stall());
      @(posedge clk);
      model_clock();
      #1;
      check_output($sformatf("rnd%0d", c), m_a, m_b, m_valid);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fwd_sel_ctrl.md
# fwd_sel_ctrl

Registered forwarding-select generator that drives the 2-bit `sel` inputs of the two 64-bit 4:1 operand muxes at the front of the EX stage. It tracks destination registers of instructions in flight through EX and MEM, and computes each operand's select code during ID. The codes are registered so they arrive at the muxes in the same cycle as the instruction's operands. It also detects load-use hazards, asserts a decode stall, and injects a bubble into EX.

## Interface
- `REG_W`, default 5: architectural register index width.
- `ZERO_REG`, default 31: register index read as XZR, never forwarded.

Ports:
- `clk` in 1: clock, rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rn` in REG_W: operand A source register.
- `id_rn_used` in 1: operand A reads `id_rn`.
- `id_rm` in REG_W: operand B source register.
- `id_rm_used` in 1: operand B reads `id_rm`.
- `id_rd` in REG_W: ID destination register.
- `id_reg_write` in 1: ID instruction writes `id_rd`.
- `id_mem_read` in 1: ID instruction is a load.
- `ex_flush` in 1: squash the instruction entering EX at this edge (branch redirect).
- `ex_sel_a` out 2: select for operand A mux.
- `ex_sel_b` out 2: select for operand B mux.
- `ex_valid` out 1: EX slot holds a real instruction.
- `id_stall` out 1: combinational; hold PC and IF/ID this cycle.

## Operation
- Select encoding:
  - 00: register-file read.
  - 01: EX/MEM ALU result.
  - 10: MEM/WB writeback value.
  - 11: constant zero (XZR).
- Internal stage state:
  - EX slot: `ex_valid`, `ex_rd`, `ex_wr`, `ex_ld`.
  - MEM slot: `mem_valid`, `mem_rd`, `mem_wr`.
- Per-operand code, computed in ID for source `s` with use flag `u`:
  - `u`=0 → 00.
  - `s`==ZERO_REG → 11.
  - EX slot valid, `ex_wr`, `ex_rd`==`s` → 01.
  - MEM slot valid, `mem_wr`, `mem_rd`==`s` → 10.
  - otherwise → 00.
  - Priority is in that order: a younger producer wins over an older one.
- Older writers (WB and beyond) need no forwarding. The register file is write-before-read.
- Load-use hazard: `id_stall` = `id_valid` & EX slot valid & `ex_ld` & `ex_wr` & `ex_rd`!=ZERO_REG & ((`id_rn_used` & `id_rn`==`ex_rd`) | (`id_rm_used` & `id_rm`==`ex_rd`)).
- Each rising edge, the MEM slot takes the EX slot contents unconditionally.
- Each rising edge, the EX slot is loaded as follows:
  - `ex_flush`=1 → bubble: valid 0, wr 0, ld 0, sels 00. Flush overrides stall.
  - else `id_stall`=1 → bubble. The ID instruction re-evaluates next cycle, against the load now in MEM, and gets code 10.
  - else `id_valid`=0 → bubble.
  - else → valid 1, rd=`id_rd`, wr=`id_reg_write`, ld=`id_mem_read`, sels = computed codes.
- A destination of ZERO_REG is recorded but never matches, because the 11 rule takes precedence.

## Timing
- Reset (async assert, sync release at the next edge): `ex_sel_a`=00, `ex_sel_b`=00, `ex_valid`=0, all slot valid/wr/ld bits 0.
- `id_stall` is valid one cycle after reset release at the earliest. It is 0 while in reset.
- Latency: select codes appear at the outputs exactly 1 cycle after the instruction is presented in ID, in the same cycle the instruction occupies EX.
- A load-use stall always lasts exactly 1 cycle. No back-to-back stall is possible on the same load.
- `id_stall` is purely combinational from ID inputs and registered EX state. It has no path from `ex_flush`.
- Reset asserted mid-stall clears all state immediately. After release, no stall and no forward originate from pre-reset instructions.

## Test plan
- Back-to-back dependency:
  - Stimulus: ADD X1 (rd=1, wr=1), then SUB reading rn=1, rm=2.
  - Response: the SUB's EX cycle shows `ex_sel_a`=01 and `ex_sel_b`=00.
- Distance-2 dependency:
  - Stimulus: writer to X3, one unrelated instruction, then a reader with rm=3.
  - Response: `ex_sel_b`=10.
- Double producer:
  - Stimulus: X4 written by instructions i and i+1, then i+2 reads rn=4.
  - Response: `ex_sel_a`=01 (the younger producer wins).
- Load-use:
  - Stimulus: LDR X5 (ld=1), then a reader with rn=5.
  - Response: `id_stall`=1 for one cycle, and the next EX cycle has `ex_valid`=0.
  - The following cycle has `ex_valid`=1 and `ex_sel_a`=10.
- XZR:
  - Stimulus: writer with rd=31, then a reader with rn=31 and rm=31.
  - Response: both sels are 11, and there is no stall even when the writer is a load.
- Flush/reset:
  - Stimulus: `ex_flush`=1 during a load-use stall.
  - Response: EX is a bubble with sels 00.
  - Stimulus: `rst_n` pulsed low mid-stream.
  - Response: outputs go to 00/0 immediately, and the first post-reset reader sees sel 00.
